// File: rtl/cat_image_loader.sv
// cat_image_loader: APB write sequencer for one CatRecognizer run.
// Clears Start_work, packs 3 pixels per word, starts, waits, captures result.
module cat_image_loader #(
  parameter int Amba_Word        = 24,
  parameter int Amba_Addr_Depth  = 13,
  parameter int PixelWidth       = 8,
  parameter int ImageWords       = 4096,
  parameter int ResultWaitCycles = 4150
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       pix_valid,
  input  logic [PixelWidth-1:0]      pix_data,
  output logic                       pix_ready,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [Amba_Addr_Depth-1:0] PADDR,
  output logic [Amba_Word-1:0]       PWDATA,
  input  logic                       CatRecOut,
  output logic                       busy,
  output logic                       done,
  output logic                       cat_result
);

  localparam int IW = $clog2(ImageWords + 1);
  localparam int CW = $clog2(ResultWaitCycles + 1);

  typedef enum logic [3:0] {
    IDLE,
    CLR_SETUP,
    CLR_ACCESS,
    GATHER,
    WR_SETUP,
    WR_ACCESS,
    GO_SETUP,
    GO_ACCESS,
    WAIT,
    DONE
  } state_t;

  state_t                  state;
  logic [IW-1:0]           word_idx;
  logic [IW-1:0]           next_idx;
  logic [1:0]              byte_cnt;
  logic [2*PixelWidth-1:0] pack;
  logic [CW-1:0]           wait_cnt;
  logic                    abort_pend;

  assign next_idx = word_idx + IW'(1);

  // Sequencer: every output is registered and set on the transition into a state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_idx   <= '0;
      byte_cnt   <= '0;
      pack       <= '0;
      wait_cnt   <= '0;
      abort_pend <= 1'b0;
      pix_ready  <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cat_result <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= CLR_SETUP;
            busy       <= 1'b1;
            PSEL       <= 1'b1;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b1;
            PADDR      <= '0;
            PWDATA     <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            abort_pend <= 1'b0;
          end
        end
        CLR_SETUP: begin
          state   <= CLR_ACCESS;
          PENABLE <= 1'b1;
          if (abort) abort_pend <= 1'b1;
        end
        CLR_ACCESS: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          PWRITE  <= 1'b0;
          if (abort || abort_pend) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state     <= GATHER;
            pix_ready <= 1'b1;
          end
        end
        GATHER: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pix_ready <= 1'b0;
            byte_cnt  <= '0;
          end else if (pix_valid) begin
            if (byte_cnt == 2'd2) begin
              state     <= WR_SETUP;
              pix_ready <= 1'b0;
              byte_cnt  <= '0;
              word_idx  <= next_idx;
              PSEL      <= 1'b1;
              PWRITE    <= 1'b1;
              PADDR     <= Amba_Addr_Depth'(next_idx);
              PWDATA    <= {pack, pix_data};
            end else begin
              pack     <= {pack[PixelWidth-1:0], pix_data};
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        WR_SETUP: begin
          state   <= WR_ACCESS;
          PENABLE <= 1'b1;
          if (abort) abort_pend <= 1'b1;
        end
        WR_ACCESS: begin
          PENABLE <= 1'b0;
          if (abort || abort_pend) begin
            PSEL   <= 1'b0;
            PWRITE <= 1'b0;
            state  <= IDLE;
            busy   <= 1'b0;
          end else if (word_idx == IW'(ImageWords)) begin
            state  <= GO_SETUP;
            PADDR  <= '0;
            PWDATA <= Amba_Word'(1);
          end else begin
            PSEL      <= 1'b0;
            PWRITE    <= 1'b0;
            state     <= GATHER;
            pix_ready <= 1'b1;
          end
        end
        GO_SETUP: begin
          state   <= GO_ACCESS;
          PENABLE <= 1'b1;
          if (abort) abort_pend <= 1'b1;
        end
        GO_ACCESS: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          PWRITE  <= 1'b0;
          if (abort || abort_pend) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= WAIT;
            wait_cnt <= CW'(ResultWaitCycles - 1);
          end
        end
        WAIT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wait_cnt <= CW'(1)) begin
            state      <= DONE;
            done       <= 1'b1;
            cat_result <= CatRecOut;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cat_image_loader.sv
// tb_cat_image_loader: scoreboard bench, small image (4 words, 10-cycle wait).
// Stimulus pushes expected APB writes/results; a negedge monitor checks them.
module tb_cat_image_loader;

  localparam int WORDS  = 4;
  localparam int WAIT_C = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        pix_ready;
  logic        PSEL, PENABLE, PWRITE;
  logic [12:0] PADDR;
  logic [23:0] PWDATA;
  logic        CatRecOut = 1'b0;
  logic        busy, done, cat_result;

  cat_image_loader #(
    .Amba_Word(24),
    .Amba_Addr_Depth(13),
    .PixelWidth(8),
    .ImageWords(WORDS),
    .ResultWaitCycles(WAIT_C)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .CatRecOut(CatRecOut),
    .busy(busy), .done(done), .cat_result(cat_result)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int data;} wr_t;

  wr_t        exp_q[$];
  bit         exp_res[$];
  logic [7:0] pix_q[$];
  int         errors = 0;
  int         checks = 0;
  int         mode = 0;
  bit         tog = 1'b0;
  bit         drv_v;
  bit         model_cat = 1'b0;
  bit         go_seen = 1'b0;
  int         cyc = 0;
  int         go_cyc = 0;
  bit         in_setup = 1'b0;
  int         sa, sd;
  bit         done_prev = 1'b0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // pixel source: always / every-other-cycle / random valid
  always @(negedge clk) begin
    drv_v = 1'b0;
    if (pix_q.size() > 0) begin
      case (mode)
        0: drv_v = 1'b1;
        1: drv_v = tog;
        default: drv_v = 1'($urandom_range(0, 1));
      endcase
    end
    tog = ~tog;
    pix_valid = drv_v;
    pix_data = drv_v ? pix_q[0] : 8'($urandom);
    if (drv_v && pix_ready && !rst) void'(pix_q.pop_front());
  end

  // monitor: APB protocol, scoreboard pops, done/result checks
  always @(negedge clk) begin
    wr_t w;
    bit  r;
    if (rst) begin
      in_setup = 1'b0;
      done_prev = 1'b0;
    end else begin
      cyc++;
      chk(!(pix_ready && PSEL), "ready_during_apb", {pix_ready, PSEL}, 0);
      if (PSEL) chk(PWRITE, "pwrite", PWRITE, 1);
      if (PSEL && !PENABLE) begin
        chk(!in_setup, "double_setup", in_setup, 0);
        in_setup = 1'b1;
        sa = int'(PADDR);
        sd = int'(PWDATA);
      end else if (PSEL && PENABLE) begin
        chk(in_setup && sa == int'(PADDR) && sd == int'(PWDATA),
            "apb_setup_stable", PADDR, sa);
        in_setup = 1'b0;
        if (exp_q.size() == 0) begin
          chk(1'b0, "apb_unexpected", {PADDR, PWDATA}, 0);
        end else begin
          w = exp_q.pop_front();
          chk(int'(PADDR) == w.addr, "apb_addr", PADDR, w.addr);
          chk(int'(PWDATA) == w.data, "apb_data", PWDATA, w.data);
          if (w.addr == 0 && w.data == 1) begin
            go_cyc = cyc;
            go_seen = 1'b1;
          end
        end
      end else begin
        chk(!PENABLE, "penable_without_psel", PENABLE, 0);
        chk(!in_setup, "setup_without_access", in_setup, 0);
        in_setup = 1'b0;
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          chk(1'b0, "done_unexpected", done, 0);
        end else begin
          r = exp_res.pop_front();
          chk(cat_result == r, "cat_result", cat_result, r);
          chk(cyc - go_cyc == WAIT_C, "done_latency", cyc - go_cyc, WAIT_C);
        end
      end
      if (done_prev) chk(!busy, "busy_after_done", busy, 0);
      done_prev = done;
    end
  end

  // reference model: bytes -> packed words, first pixel in MSBs
  task automatic push_image(input bit seq);
    logic [7:0] b[3*WORDS];
    wr_t        w;
    for (int i = 0; i < 3 * WORDS; i++)
      b[i] = seq ? 8'(i + 1) : 8'($urandom);
    exp_q.push_back('{0, 0});
    for (int k = 0; k < WORDS; k++) begin
      w.addr = k + 1;
      w.data = int'(b[3*k]) * 65536 + int'(b[3*k+1]) * 256 + int'(b[3*k+2]);
      exp_q.push_back(w);
    end
    exp_q.push_back('{0, 1});
    for (int i = 0; i < 3 * WORDS; i++) pix_q.push_back(b[i]);
  endtask

  task automatic expect_result(input bit c);
    CatRecOut = c;
    exp_res.push_back(c);
    model_cat = c;
  endtask

  task automatic pulse_start(input bit with_abort);
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(!busy, nm, busy, 0);
  endtask

  task automatic wait_go(input string nm);
    int n = 0;
    while (!go_seen && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(go_seen, nm, go_seen, 1);
  endtask

  task automatic check_all_zero(input string nm);
    chk({PSEL, PENABLE, PWRITE} == 3'b000, {nm, "_apb_ctl"},
        {PSEL, PENABLE, PWRITE}, 0);
    chk(PADDR == 0 && PWDATA == 0, {nm, "_apb_bus"}, {PADDR, PWDATA}, 0);
    chk({pix_ready, busy, done, cat_result} == 4'b0000, {nm, "_status"},
        {pix_ready, busy, done, cat_result}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // sequential bytes, valid always high, result 1
    mode = 0;
    push_image(1'b1);
    expect_result(1'b1);
    pulse_start(1'b0);
    chk(busy, "busy_after_start", busy, 1);
    wait_idle("t1_idle");

    // toggled valid, result 0, start+abort together in idle
    mode = 1;
    go_seen = 1'b0;
    push_image(1'b0);
    expect_result(1'b0);
    pulse_start(1'b1);
    chk(busy, "start_beats_abort", busy, 1);
    wait_idle("t2_idle");

    // random valid, random result, start pulsed during wait
    mode = 2;
    go_seen = 1'b0;
    push_image(1'b0);
    expect_result(1'($urandom_range(0, 1)));
    pulse_start(1'b0);
    wait_go("t3_go");
    repeat (3) @(negedge clk);
    pulse_start(1'b0);
    wait_idle("t3_idle");
    repeat (15) @(negedge clk);
    chk(!busy, "start_in_wait_ignored", busy, 0);

    // abort during WR_SETUP of word 1
    mode = 0;
    exp_q.push_back('{0, 0});
    exp_q.push_back('{1, 32'h00a1b2c3});
    pix_q.push_back(8'ha1);
    pix_q.push_back(8'hb2);
    pix_q.push_back(8'hc3);
    pulse_start(1'b0);
    n = 0;
    while (!(PSEL && !PENABLE && PADDR == 13'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(PSEL && !PENABLE && PADDR == 13'd1, "t4_reach_wr_setup", PADDR, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk(PSEL && PENABLE, "abort_access_completes", {PSEL, PENABLE}, 3);
    @(negedge clk);
    chk(!PSEL && !busy, "abort_to_idle", {PSEL, busy}, 0);
    chk(cat_result == model_cat, "abort_keeps_result", cat_result, model_cat);
    repeat (20) @(negedge clk);
    chk(!busy, "abort_stays_idle", busy, 0);

    // abort during WAIT: full image written, no done
    go_seen = 1'b0;
    push_image(1'b0);
    pulse_start(1'b0);
    wait_go("t5_go");
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    chk(!busy, "abort_in_wait", busy, 0);
    repeat (15) @(negedge clk);
    chk(cat_result == model_cat, "wait_abort_keeps", cat_result, model_cat);

    // reset during GATHER after 2 bytes, then a fresh image
    exp_q.push_back('{0, 0});
    pix_q.push_back(8'h55);
    pix_q.push_back(8'h66);
    pulse_start(1'b0);
    n = 0;
    while (pix_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk(exp_q.size() == 0, "clr_before_reset", exp_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    model_cat = 1'b0;
    go_seen = 1'b0;
    push_image(1'b1);
    expect_result(1'b1);
    pulse_start(1'b0);
    wait_idle("t6_idle");

    repeat (3) @(negedge clk);
    chk(exp_q.size() == 0, "writes_drained", exp_q.size(), 0);
    chk(exp_res.size() == 0, "results_drained", exp_res.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cat_image_loader.md
Name: cat_image_loader

Overview:
APB master sequencer that drives one full CatRecognizer classification: clears Start_work, streams image pixels in as bytes, packs 3 pixels per APB word, writes them to addresses 1..ImageWords, then sets Start_work. It then waits a fixed compute window and captures CatRecOut. It sits between a pixel source (DMA/host FIFO) and the CatRecognizer APB slave port, and replaces the hand-driven CPU sequence used in simulation.

Parameters:
Amba_Word, 24, APB data width; must equal 3*PixelWidth
Amba_Addr_Depth, 13, APB address width
PixelWidth, 8, pixel byte width
ImageWords, 4096, number of packed pixel words per image (12288 pixels)
ResultWaitCycles, 4150, clocks from end of Start_work write to CatRecOut sample

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to load+classify one image; ignored unless idle
abort  in  1  one-cycle request to stop current image; ignored when idle
pix_valid  in  1  pixel byte valid
pix_data  in  PixelWidth  pixel byte
pix_ready  out  1  loader accepts pixel byte this cycle (transfer = valid&ready)
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB write
PADDR  out  Amba_Addr_Depth  APB address
PWDATA  out  Amba_Word  APB write data
CatRecOut  in  1  classifier result from CatRecognizer
busy  out  1  high from cycle after accepted start until done/abort return to idle
done  out  1  one-cycle pulse when cat_result is updated
cat_result  out  1  captured CatRecOut, held until next done

Behaviour:
- Reset (synchronous, rst=1 at clock edge): all outputs 0, state IDLE, counters 0. Reset mid-transfer drops PSEL/PENABLE in the next cycle; no completion of the access.
- APB: no PREADY/PSLVERR. Every access = SETUP cycle (PSEL=1, PENABLE=0) then ACCESS cycle (PSEL=1, PENABLE=1); PADDR/PWDATA/PWRITE stable across both. PSEL=0 otherwise. Only writes are issued (PWRITE=1 whenever PSEL=1).
- FSM: IDLE -> CLR_SETUP -> CLR_ACCESS -> GATHER -> WR_SETUP -> WR_ACCESS -> (GATHER | GO_SETUP) -> GO_ACCESS -> WAIT -> DONE -> IDLE.
- IDLE: start=1 -> CLR_SETUP next cycle (PSEL rises 1 cycle after start). busy=1 in all non-IDLE states.
- CLR_*: write PADDR=0, PWDATA=0 (Start_work=0).
- GATHER: pix_ready=1 only here. Byte counter 0..2; byte0 -> PWDATA[23:16], byte1 -> [15:8], byte2 -> [7:0] (first pixel in MSBs). On third accepted byte go WR_SETUP; counter resets to 0. pix_ready=0 in all other states; bytes offered then are not consumed.
- WR_*: PADDR = word index, starting at 1, +1 per word. After ACCESS of word ImageWords -> GO_SETUP, else -> GATHER. Minimum 5 cycles per word.
- GO_*: PADDR=0, PWDATA = 1 (bit0 Start_work=1, others 0).
- WAIT: counter loads ResultWaitCycles-1 on entry, decrements each cycle; at 0 go DONE.
- DONE (1 cycle): cat_result <= CatRecOut, done=1; next cycle IDLE, busy=0.
- start while busy: ignored. start and abort same cycle in IDLE: start wins.
- abort: in GATHER or WAIT -> IDLE next cycle. In any SETUP state -> complete that access's ACCESS cycle, then IDLE. Never truncates an APB access. Partial bytes are discarded. No done pulse; cat_result unchanged.
- Word index and byte counter wrap-free: index width ceil(log2(ImageWords+1)) and <= Amba_Addr_Depth.

Test Plan:
- ImageWords=4, ResultWaitCycles=10; start, then bytes 0x01..0x0C with pix_valid always high -> APB writes (0,0x000000), (1,0x010203), (2,0x040506), (3,0x070809), (4,0x0A0B0C), (0,0x000001), each exactly 2 cycles.
- Same config, CatRecOut=1 held -> done pulses exactly 10 cycles after GO_ACCESS cycle, cat_result=1, busy falls next cycle. Repeat with CatRecOut=0 -> cat_result=0.
- pix_valid toggled every other cycle -> identical APB data/address sequence; pix_ready never high during APB cycles.
- start pulsed during WAIT -> ignored, single done. abort during WR_SETUP -> WR_ACCESS completes, then PSEL=0, busy=0, no done.
- rst asserted during GATHER after 2 bytes -> next cycle all outputs 0; fresh start produces word 1 from next 3 bytes.
- Default params (4096 words, 4150 wait) vs. CatRecognizer with image files 0..39 -> cat_result matches expected results list.
